// File: rtl/rtc_read_seq.sv
// Reads nine RTC registers over a multiplexed AD bus; sequence is 36*T_PHASE+1 cycles from first ADDR to DONE.
// No backpressure: a started sequence always completes; lee/escribe are only looked at in IDLE.
module rtc_read_seq #(
    parameter int T_PHASE = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lee,
    input  logic       escribe,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] t_seg,
    output logic [7:0] t_min,
    output logic [7:0] t_hora
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP, READ, RECOV, DONE} state_t;

    state_t      state, state_nx;
    logic [11:0] phase;
    logic [3:0]  idx;
    logic        phase_last;
    logic [7:0]  regs [0:8];
    logic [7:0]  addr;

    assign phase_last = (phase == 12'(T_PHASE - 1));

    always_comb begin
        case (idx)
            4'd0:    addr = 8'h21;
            4'd1:    addr = 8'h22;
            4'd2:    addr = 8'h23;
            4'd3:    addr = 8'h24;
            4'd4:    addr = 8'h25;
            4'd5:    addr = 8'h26;
            4'd6:    addr = 8'h41;
            4'd7:    addr = 8'h42;
            4'd8:    addr = 8'h43;
            default: addr = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= 12'd0;
            idx   <= 4'd0;
            for (int i = 0; i < 9; i++) regs[i] <= 8'h00;
        end else begin
            state <= state_nx;
            // phase restarts on every state entry, so each phase is exactly T_PHASE long
            if (state_nx != state || state == IDLE)
                phase <= 12'd0;
            else
                phase <= phase + 12'd1;
            if (state == IDLE)
                idx <= 4'd0;
            else if (state == RECOV && phase_last && idx != 4'd8)
                idx <= idx + 4'd1;
            if (state == READ && phase_last)
                regs[idx] <= ad_in;
        end
    end

    always_comb begin
        state_nx = state;
        cs_n     = 1'b1;
        ad_n     = 1'b1;
        wr_n     = 1'b1;
        rd_n     = 1'b1;
        ad_oe    = 1'b0;
        ad_out   = 8'h00;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (lee && !escribe) state_nx = ADDR;
            end
            ADDR: begin
                cs_n   = 1'b0;
                ad_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
                if (phase_last) state_nx = GAP;
            end
            GAP: begin
                if (phase_last) state_nx = READ;
            end
            READ: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
                if (phase_last) state_nx = RECOV;
            end
            RECOV: begin
                if (phase_last) state_nx = (idx == 4'd8) ? DONE : ADDR;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign seg    = regs[0];
    assign min    = regs[1];
    assign hora   = regs[2];
    assign dia    = regs[3];
    assign mes    = regs[4];
    assign anio   = regs[5];
    assign t_seg  = regs[6];
    assign t_min  = regs[7];
    assign t_hora = regs[8];

endmodule

// File: tb/tb_rtc_read_seq.sv
// Randomized bench for rtc_read_seq: a bus-level model derives addresses, phase lengths and captured values.
module tb_rtc_read_seq;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset, lee, escribe;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done;
    logic [7:0] seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora;

    rtc_read_seq #(.T_PHASE(T)) dut (
        .clk(clk), .reset(reset), .lee(lee), .escribe(escribe), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .busy(busy), .done(done), .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes),
        .anio(anio), .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [7:0] addr_tab [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] exp_r [0:8];
    int         seq_pos = 0, seq_cyc = 0, cur_idx = 0, prev_cls = 0, run = 0, mode = 0;
    logic       prev_rd = 1'b1;
    logic [7:0] last_rd = 8'h00;

    function automatic logic [71:0] dut_regs();
        return {seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora};
    endfunction

    function automatic logic [71:0] exp_regs();
        return {exp_r[0], exp_r[1], exp_r[2], exp_r[3], exp_r[4], exp_r[5], exp_r[6], exp_r[7], exp_r[8]};
    endfunction

    // one clock: observe outputs at the falling edge, update model, drive ad_in for the next edge
    task automatic tick();
        logic       r;
        int         cls;
        logic [4:0] pat;
        r = reset;
        @(negedge clk);
        if (r) begin
            for (int i = 0; i < 9; i++) exp_r[i] = 8'h00;
            seq_pos = 0; seq_cyc = 0; prev_cls = 0; run = 0; prev_rd = 1'b1;
            check("rst_strobes", {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done}, 7'b1111000);
            check("rst_ad_out", ad_out, 8'h00);
        end else begin
            cls = !busy ? 0 : done ? 4 : ad_oe ? 1 : !rd_n ? 3 : 2;
            if (!prev_rd && rd_n) exp_r[cur_idx] = last_rd;
            if (busy) seq_cyc++;
            if (cls != prev_cls) begin
                if (prev_cls >= 1 && prev_cls <= 3) check("phase_len", run, T);
                if (prev_cls == 4) check("done_len", run, 1);
                if (prev_cls == 0) check("start_in_addr", cls, 1);
                if (cls == 1) begin
                    if (prev_cls == 0) begin
                        seq_pos = 0;
                        seq_cyc = 1;
                    end
                    if (seq_pos < 9) begin
                        check("addr", ad_out, addr_tab[seq_pos]);
                        cur_idx = seq_pos;
                    end else begin
                        check("addr_count", seq_pos, 8);
                    end
                    seq_pos++;
                end
                run = 1;
            end else begin
                run++;
            end
            case (cls)
                1:       pat = 5'b00011;
                3:       pat = 5'b01100;
                default: pat = 5'b11110;
            endcase
            check("strobes", {cs_n, ad_n, wr_n, rd_n, ad_oe}, pat);
            check("oe_with_rd", ad_oe & ~rd_n, 1'b0);
            if (!ad_oe) check("ad_out_idle", ad_out, 8'h00);
            if (done) begin
                check("done_cycle", seq_cyc, 36 * T + 1);
                check("done_count", seq_pos, 9);
            end
            prev_cls = cls;
            prev_rd  = rd_n;
        end
        check("regs", dut_regs(), exp_regs());
        if (mode == 0) ad_in = !rd_n ? 8'h10 + 8'(cur_idx) : 8'hee;
        else           ad_in = 8'($urandom);
        if (!rd_n) last_rd = ad_in;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < maxc);
        check("wait_done", done, 1'b1);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; lee = 1'b0; escribe = 1'b0; ad_in = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // single lee pulse, RTC returns 0x10+index
        mode = 0;
        lee = 1'b1;
        tick();
        lee = 1'b0;
        check("t1_started", ad_oe, 1'b1);
        wait_done(200);
        check("t1_seq_cyc", seq_cyc, 145);
        check("t1_regs", dut_regs(), 72'h10_11_12_13_14_15_16_17_18);
        repeat (3) tick();

        // escribe inhibits the start
        mode = 1;
        lee = 1'b1; escribe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("inhibit_busy", busy, 1'b0);
            check("inhibit_cs", cs_n, 1'b1);
        end
        escribe = 1'b0;
        tick();
        lee = 1'b0;
        check("release_addr", {ad_oe, cs_n}, 2'b10);
        wait_done(200);
        repeat (3) tick();

        // reset on the last READ cycle of 0x24
        lee = 1'b1;
        tick();
        lee = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = (prev_cls == 3 && cur_idx == 3 && run == T);
        end
        check("reach_read_24", ok, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_dia", dia, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        repeat (3) tick();
        check("rst_mid_stays_idle", busy, 1'b0);

        // lee held high: back-to-back sequences with one idle cycle between
        lee = 1'b1;
        wait_done(200);
        tick();
        check("b2b_idle", busy, 1'b0);
        tick();
        check("b2b_restart", cs_n, 1'b0);
        lee = 1'b0;
        wait_done(200);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rtc_read_seq.md
RTC_READ_SEQ -- requirements
Module: rtc_read_seq

Interface
REQ-001 SHALL have parameter T_PHASE, default 36, cycles per bus phase (legal range 1..4095).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port lee  input  1  read-sequence request, level-sampled.
REQ-005 SHALL have port escribe  input  1  write-in-progress inhibit; blocks a new start.
REQ-006 SHALL have port ad_in  input  8  RTC multiplexed address/data bus, read side.
REQ-007 SHALL have port ad_out  output  8  address driven onto the RTC bus.
REQ-008 SHALL have port ad_oe  output  1  1 = ad_out drives the bus.
REQ-009 SHALL have ports cs_n, ad_n, wr_n, rd_n  output  1 each  active-low RTC strobes.
REQ-010 SHALL have port busy  output  1  high while a sequence runs.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-012 SHALL have ports seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora  output  8 each  captured register values.

Function
REQ-013 SHALL read exactly 9 registers per sequence, in the order 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43, mapped respectively to seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora.
REQ-014 SHALL implement the states IDLE, ADDR, GAP, READ, RECOV and DONE.
REQ-015 SHALL transition IDLE->ADDR with index 0 on a cycle where lee=1 and escribe=0; with escribe=1 it SHALL remain in IDLE.
REQ-016 SHALL hold each of ADDR, GAP, READ and RECOV for exactly T_PHASE cycles, using a phase counter cleared on every state entry.
REQ-017 In ADDR, SHALL drive cs_n=0, ad_n=0, wr_n=0, rd_n=1, ad_oe=1, and ad_out=address[index].
REQ-018 In GAP, SHALL drive all strobes=1 and ad_oe=0.
REQ-019 In READ, SHALL drive cs_n=0, rd_n=0, ad_n=1, wr_n=1 and ad_oe=0.
REQ-020 On the last READ cycle, SHALL sample ad_in into the output register for the current index.
REQ-021 In RECOV, SHALL drive all strobes=1 and ad_oe=0.
REQ-022 At the end of RECOV, SHALL increment index and go to ADDR if index<8, and go to DONE otherwise.
REQ-023 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-024 A sequence SHALL NOT be restarted back-to-back from DONE; lee still high in IDLE starts a new sequence 1 cycle later.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A full sequence SHALL take 36*T_PHASE+1 cycles from the first ADDR cycle through DONE (1297 cycles at the default).
REQ-027 lee and escribe SHALL be ignored outside IDLE; a sequence in progress always completes.
REQ-028 Each output register SHALL change only on its own capture cycle and SHALL hold its value otherwise, including across sequences.
REQ-029 ad_oe=1 and rd_n=0 SHALL never occur in the same cycle.
REQ-030 cs_n SHALL be 1 in IDLE, DONE, GAP and RECOV.
REQ-031 ad_out SHALL be 8'h00 whenever ad_oe=0, and SHALL NOT be high-impedance.
REQ-032 The index and phase counters SHALL NOT wrap within a sequence; reaching the terminal index ends the sequence.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL go to IDLE and clear index and phase counter to 0.
REQ-034 Reset SHALL set cs_n=ad_n=wr_n=rd_n=1, ad_oe=0, ad_out=0, busy=0 and done=0.
REQ-035 Reset SHALL set all nine captured registers to 8'h00.
REQ-036 Reset SHALL take priority over every other input, including in mid-sequence; no capture occurs on the reset cycle.

Verification
REQ-037 Bench SHALL cover: T_PHASE=4, RTC model returning 8'h10+index; pulse lee -> ad_out sequence 21,22,23,24,25,26,41,42,43, seg=10 through t_hora=18, done one cycle at cycle 145.
REQ-038 Bench SHALL cover: lee=1 with escribe=1 for 20 cycles -> busy=0 and strobes idle; drop escribe -> ADDR entered the next cycle.
REQ-039 Bench SHALL cover: reset asserted during READ of 0x24 -> next cycle IDLE, all outputs 0, no write to dia.
REQ-040 Bench SHALL cover: lee held high continuously -> done pulse followed, 2 cycles later, by cs_n=0 of a new sequence, with values updated.
REQ-041 Bench SHALL cover: monitor over all tests -> no cycle with ad_oe=1 and rd_n=0, and every phase exactly T_PHASE cycles long.
REQ-042 Bench SHALL cover: ad_in changing every cycle during READ -> the captured value equals ad_in at the last READ cycle only.
